// File: rtl/fir_pkg.sv
// Shared FIR datapath types: sample width and the signed sample type used by
// the input FIFO, the FIR core and the coefficient ROM.
package fir_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sync_rise_det.sv
// Brings a slow strobe into the fast clock domain and emits a one-cycle pulse
// on each of its rising edges; falling edges produce nothing.
module sync_rise_det (
  input  logic clk_in,
  input  logic reset_n,
  input  logic strobe,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 form the synchroniser, s3 holds the previous synchronised level
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/fir_sample_fifo.sv
// Input stage of the FIR: captures one ADC word per divided-clock rising edge
// into a small first-word-fall-through FIFO drained by a valid/ready handshake.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 8
) (
  input  logic                       clk_in,
  input  logic                       reset_n,
  input  logic                       clk_slow,
  input  logic signed [DATA_W-1:0]   adc_data,
  input  logic                       clr_ovf,
  output logic signed [DATA_W-1:0]   m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        rd_ptr;
  logic                     cap;
  logic                     full;
  logic                     pop;
  logic                     push;
  logic                     drop;

  sync_rise_det u_rise (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .strobe  (clk_slow),
    .rise    (cap)
  );

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the FIR core is draining.
  assign full = (level == FULL_LVL);
  assign pop  = m_valid & m_ready;
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= adc_data;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // a drop in the same cycle wins over the clear
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Gating with m_valid keeps the unreset memory from showing X after reset.
  assign m_valid = (level != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Directed bench for fir_sample_fifo: edge capture, fill/overflow, full-with-pop,
// latency, overflow clear priority and mid-operation reset.
module tb_fir_sample_fifo;

  logic               clk_in = 1'b0;
  logic               reset_n = 1'b0;
  logic               clk_slow = 1'b0;
  logic signed [15:0] adc_data = '0;
  logic               clr_ovf = 1'b0;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [3:0]         level;
  logic               overflow;

  int checks = 0;
  int failures = 0;

  fir_sample_fifo #(.DATA_W(16), .DEPTH(8)) dut (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .clk_slow (clk_slow),
    .adc_data (adc_data),
    .clr_ovf  (clr_ovf),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // One full clk_slow pulse; the capture edge lands before the call returns.
  task automatic slow_pulse(input logic [15:0] d);
    adc_data = d;
    clk_slow = 1'b1;
    cyc(3);
    clk_slow = 1'b0;
    cyc(3);
  endtask

  int pops;
  int max_lvl;

  initial begin
    cyc(3);
    check("rst_level", int'(level), 0);
    check("rst_valid", int'(m_valid), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_data", int'($unsigned(m_data)), 0);
    reset_n = 1'b1;
    cyc(2);

    // Free-running divider, always-ready sink
    m_ready  = 1'b1;
    adc_data = 16'h1234;
    pops = 0;
    max_lvl = 0;
    for (int i = 0; i < 504; i++) begin
      clk_slow = ((i % 126) < 63);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (m_valid && m_ready) begin
        pops++;
        check("free_data", int'($unsigned(m_data)), 32'h1234);
      end
      cyc(1);
    end
    clk_slow = 1'b0;
    check("free_pops", pops, 4);
    check("free_maxlvl", max_lvl, 1);
    check("free_empty", int'(level), 0);

    // Fill with the sink stalled, then overflow on the ninth edge
    m_ready = 1'b0;
    cyc(4);
    for (int k = 1; k <= 8; k++) slow_pulse(16'(k));
    check("fill_level", int'(level), 8);
    check("fill_ovf", int'(overflow), 0);
    slow_pulse(16'd9);
    check("ovf_set", int'(overflow), 1);
    check("ovf_level", int'(level), 8);

    // Clear without a push, then clear coincident with a dropped push
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    check("clr_ovf", int'(overflow), 0);
    adc_data = 16'd99;
    clk_slow = 1'b1;
    cyc(2);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    check("clr_vs_drop", int'(overflow), 1);
    check("drop_level", int'(level), 8);
    clk_slow = 1'b0;
    cyc(3);

    // Drain in order
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("drain_valid", int'(m_valid), 1);
      check("drain_data", int'($unsigned(m_data)), k);
      cyc(1);
    end
    m_ready = 1'b0;
    check("drain_empty", int'(level), 0);
    check("drain_valid0", int'(m_valid), 0);

    // Full FIFO with a pop in the same cycle as the capture
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    for (int k = 11; k <= 18; k++) slow_pulse(16'(k));
    check("full2_level", int'(level), 8);
    adc_data = 16'd19;
    clk_slow = 1'b1;
    cyc(2);
    m_ready = 1'b1;
    cyc(1);
    m_ready = 1'b0;
    check("popcap_level", int'(level), 8);
    check("popcap_ovf", int'(overflow), 0);
    clk_slow = 1'b0;
    cyc(3);
    m_ready = 1'b1;
    for (int k = 12; k <= 19; k++) begin
      check("popcap_data", int'($unsigned(m_data)), k);
      cyc(1);
    end
    m_ready = 1'b0;
    check("popcap_empty", int'(level), 0);

    // Latency: driven high right after edge k, valid only after edge k+3
    adc_data = 16'h0055;
    clk_slow = 1'b1;
    cyc(1);
    check("lat_k1", int'(m_valid), 0);
    cyc(1);
    check("lat_k2", int'(m_valid), 0);
    cyc(1);
    check("lat_k3", int'(m_valid), 1);
    check("lat_data", int'($unsigned(m_data)), 32'h55);
    cyc(2);
    clk_slow = 1'b0;
    cyc(5);
    check("fall_nocap", int'(level), 1);

    // Reset with five samples queued
    for (int k = 0; k < 4; k++) slow_pulse(16'(16'h60 + k));
    check("pre_rst_level", int'(level), 5);
    reset_n = 1'b0;
    cyc(2);
    check("midrst_valid", int'(m_valid), 0);
    check("midrst_level", int'(level), 0);
    check("midrst_ovf", int'(overflow), 0);
    reset_n = 1'b1;
    cyc(2);
    slow_pulse(16'h0077);
    check("post_rst_valid", int'(m_valid), 1);
    check("post_rst_data", int'($unsigned(m_data)), 32'h77);
    check("post_rst_level", int'(level), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
